// File: rtl/cdr_pkg.sv
// Shared CDR types and constants: loop-filter FSM states,
// PRBS7 feedback taps and default accumulator/threshold sizing.
package cdr_pkg;

   typedef enum logic {
      TRACK,
      HOLD
   } state_t;

   // x^7 + x^6 + 1 : feedback from bits 6 and 5
   localparam int PRBS7_TAP_HI = 6;
   localparam int PRBS7_TAP_LO = 5;

   localparam int CDR_ACC_W  = 6;
   localparam int CDR_THRESH = 8;

endpackage

// File: rtl/prbs7_lfsr.sv
// Fibonacci PRBS7 generator, period 127 from any nonzero seed.
// Shared by the loop filter dither and the PRN data generator.
module prbs7_lfsr
   import cdr_pkg::*;
#(
   parameter logic [6:0] SEED = 7'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic [6:0] state
);

   logic fb;

   assign fb = state[PRBS7_TAP_HI] ^ state[PRBS7_TAP_LO];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SEED;
      end else if (enable) begin
         state <= {state[5:0], fb};
      end
   end

endmodule

// File: rtl/prn_loop_filter.sv
// Bang-bang CDR loop filter: saturating vote integrator with a
// dithered threshold, post-command holdoff and lock detection.
module prn_loop_filter
   import cdr_pkg::*;
#(
   parameter int         ACC_W     = CDR_ACC_W,
   parameter int         THRESH    = CDR_THRESH,
   parameter bit         DITHER_EN = 1'b1,
   parameter logic [6:0] LFSR_SEED = 7'h5A,
   parameter int         HOLDOFF   = 4,
   parameter int         LOCK_WIN  = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    up,
   input  logic                    dn,
   output logic                    shift_left,
   output logic                    shift_right,
   output logic                    lock,
   output logic signed [ACC_W-1:0] acc_out
);

   localparam int HW = $clog2(HOLDOFF + 1);
   localparam int LW = $clog2(LOCK_WIN + 1);

   localparam logic signed [ACC_W-1:0] ACC_MAX =
      ACC_W'((1 << (ACC_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_MIN =
      ACC_W'(1 - (1 << (ACC_W - 1)));
   localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

   state_t                  state, state_n;
   logic signed [ACC_W-1:0] acc, acc_n, acc_v;
   logic [HW-1:0]           hcnt, hcnt_n;
   logic [LW-1:0]           lcnt, lcnt_n;
   logic                    left_n, right_n;
   logic [6:0]              lfsr;
   logic [31:0]             dith;
   logic signed [31:0]      thr;
   logic                    unused_lfsr;

   prbs7_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .enable (1'b1),
      .state  (lfsr)
   );

   assign unused_lfsr = ^lfsr[6:2];

   // Dither uses the LFSR value from before this edge's advance
   assign dith = DITHER_EN ? {30'd0, lfsr[1:0]} : 32'd0;
   assign thr  = THRESH + signed'(dith);

   always_comb begin
      state_n = state;
      acc_n   = acc;
      acc_v   = acc;
      hcnt_n  = hcnt;
      left_n  = 1'b0;
      right_n = 1'b0;
      unique case (state)
         TRACK: begin
            if (up && !dn && acc != ACC_MAX) begin
               acc_v = acc + ONE;
            end else if (dn && !up && acc != ACC_MIN) begin
               acc_v = acc - ONE;
            end
            if (32'(acc_v) >= thr) begin
               left_n  = 1'b1;
               acc_n   = '0;
               hcnt_n  = '0;
               state_n = HOLD;
            end else if (32'(acc_v) <= -thr) begin
               right_n = 1'b1;
               acc_n   = '0;
               hcnt_n  = '0;
               state_n = HOLD;
            end else begin
               acc_n = acc_v;
            end
         end
         HOLD: begin
            acc_n = '0;
            if (hcnt == HW'(HOLDOFF - 1)) begin
               hcnt_n  = '0;
               state_n = TRACK;
            end else begin
               hcnt_n = hcnt + HW'(1);
            end
         end
      endcase
   end

   always_comb begin
      lcnt_n = lcnt;
      if (left_n || right_n) begin
         lcnt_n = '0;
      end else if (lcnt != LW'(LOCK_WIN)) begin
         lcnt_n = lcnt + LW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= TRACK;
         acc         <= '0;
         hcnt        <= '0;
         lcnt        <= '0;
         shift_left  <= 1'b0;
         shift_right <= 1'b0;
      end else begin
         state       <= state_n;
         acc         <= acc_n;
         hcnt        <= hcnt_n;
         lcnt        <= lcnt_n;
         shift_left  <= left_n;
         shift_right <= right_n;
      end
   end

   assign lock    = (lcnt == LW'(LOCK_WIN));
   assign acc_out = acc;

endmodule
